// File: rtl/calc_hs_pkg.sv
// Shared types and defaults for the ap_ctrl_hs initiator driver.
package calc_hs_pkg;

  localparam int unsigned CALC_DATA_W          = 32;
  localparam int unsigned CALC_TIMEOUT_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } calc_hs_state_t;

endpackage

// File: rtl/calc_hs_watchdog.sv
// Saturating cycle counter that flags when a call has run TIMEOUT_CYCLES cycles.
module calc_hs_watchdog
  import calc_hs_pkg::*;
#(
  parameter  int unsigned TIMEOUT_CYCLES = CALC_TIMEOUT_DEFAULT,
  localparam int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  // Count enabled cycles, holding at TIMEOUT_CYCLES; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_W'(TIMEOUT_CYCLES))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // cnt holds the cycles already spent, so the current cycle is number cnt+1.
  assign expired = en && (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/calc_hs_driver.sv
// Initiator for the HLS ap_ctrl_hs handshake: stream in operands, run one call,
// stream out the captured result (or a timeout marker).
module calc_hs_driver
  import calc_hs_pkg::*;
#(
  parameter  int unsigned DATA_W         = CALC_DATA_W,
  parameter  int unsigned TIMEOUT_CYCLES = CALC_TIMEOUT_DEFAULT,
  localparam int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_timeout,
  output logic              busy,
  output logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic              ap_idle,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] ap_return
);

  calc_hs_state_t    state, state_n;
  logic [DATA_W-1:0] a_n, b_n, res_n;
  logic              tmo_n;
  logic              wd_clr, wd_en, wd_expired;

  // ap_idle is status only and deliberately has no effect on control.
  logic unused_idle;
  assign unused_idle = ap_idle;

  calc_hs_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (ap_clk),
    .rst_n  (ap_rst_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_expired)
  );

  // Next-state and next register values; a completing ap_done beats expiry.
  always_comb begin
    state_n = state;
    a_n     = a;
    b_n     = b;
    res_n   = out_result;
    tmo_n   = out_timeout;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          a_n     = in_a;
          b_n     = in_b;
          wd_clr  = 1'b1;
          state_n = START;
        end
      end
      START: begin
        wd_en = 1'b1;
        if (ap_ready && ap_done) begin
          res_n   = ap_return;
          tmo_n   = 1'b0;
          state_n = HOLD;
        end else if (wd_expired) begin
          res_n   = '0;
          tmo_n   = 1'b1;
          state_n = HOLD;
        end else if (ap_ready) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        wd_en = 1'b1;
        if (ap_done) begin
          res_n   = ap_return;
          tmo_n   = 1'b0;
          state_n = HOLD;
        end else if (wd_expired) begin
          res_n   = '0;
          tmo_n   = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; ap_start/out_valid are decoded from next state
  // so they line up with the state they belong to without a cycle of lag.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state       <= IDLE;
      a           <= '0;
      b           <= '0;
      out_result  <= '0;
      out_timeout <= 1'b0;
      ap_start    <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      state       <= state_n;
      a           <= a_n;
      b           <= b_n;
      out_result  <= res_n;
      out_timeout <= tmo_n;
      ap_start    <= (state_n == START);
      out_valid   <= (state_n == HOLD);
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state == START) || (state == WAIT);

endmodule

// File: tb/tb_calc_hs_driver.sv
// Directed self-checking bench for calc_hs_driver with a 16-cycle watchdog.
module tb_calc_hs_driver;

  localparam int unsigned W = 32;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         out_valid, out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_timeout, busy, ap_start;
  logic         ap_ready = 1'b0, ap_done = 1'b0, ap_idle = 1'b1;
  logic [W-1:0] a, b;
  logic [W-1:0] ap_return = '0;

  int total = 0;
  int bad   = 0;

  calc_hs_driver #(
    .DATA_W(W),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_timeout(out_timeout),
    .busy       (busy),
    .ap_start   (ap_start),
    .ap_ready   (ap_ready),
    .ap_done    (ap_done),
    .ap_idle    (ap_idle),
    .a          (a),
    .b          (b),
    .ap_return  (ap_return)
  );

  always #5 ap_clk = ~ap_clk;

  // Advance into the next cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_result !== '0)  begin bad++; $display("FAIL rst_out_result got=%h exp=0", out_result); end
    total++; if (out_timeout !== 1'b0) begin bad++; $display("FAIL rst_out_timeout got=%b exp=0", out_timeout); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (ap_start !== 1'b0)  begin bad++; $display("FAIL rst_ap_start got=%b exp=0", ap_start); end
    total++; if (a !== '0 || b !== '0) begin bad++; $display("FAIL rst_ab got=%h/%h exp=0/0", a, b); end
    ap_rst_n = 1'b1;
    tick();
  endtask

  // Drain a result held in HOLD and return to IDLE.
  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_zero_latency();
    in_valid = 1'b1; in_a = 5; in_b = 7;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL zl_accept_ready got=%b exp=1", in_ready); end
    tick();                                   // T+1
    in_valid = 1'b0;
    total++; if (ap_start !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL zl_start got=%b busy=%b exp=1/1", ap_start, busy); end
    total++; if (a !== 32'd5 || b !== 32'd7) begin bad++; $display("FAIL zl_operands got=%h/%h exp=5/7", a, b); end
    ap_ready = 1'b1; ap_done = 1'b1; ap_return = 32'd12;
    tick();                                   // T+2
    ap_ready = 1'b0; ap_done = 1'b0; ap_return = '0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL zl_out_valid got=%b exp=1", out_valid); end
    total++; if (out_result !== 32'd12 || out_timeout !== 1'b0) begin bad++; $display("FAIL zl_result got=%h tmo=%b exp=c/0", out_result, out_timeout); end
    total++; if (ap_start !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL zl_hold_ctrl got start=%b rdy=%b exp=0/0", ap_start, in_ready); end
    out_ready = 1'b1;
    tick();                                   // T+3
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL zl_release got rdy=%b ov=%b exp=1/0", in_ready, out_valid); end
  endtask

  task automatic test_split();
    in_valid = 1'b1; in_a = 32'h11; in_b = 32'h22;
    tick();
    in_valid = 1'b0; in_a = 32'hFFFF; in_b = 32'hEEEE;
    for (int k = 1; k <= 10; k++) begin       // cycle T+k
      total++; if (ap_start !== (k <= 3)) begin bad++; $display("FAIL split_ap_start k=%0d got=%b exp=%b", k, ap_start, (k <= 3)); end
      total++; if (a !== 32'h11 || b !== 32'h22) begin bad++; $display("FAIL split_operands k=%0d got=%h/%h exp=11/22", k, a, b); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL split_early_valid k=%0d got=%b exp=0", k, out_valid); end
      ap_ready  = (k == 3);
      ap_done   = (k == 10);
      ap_return = (k == 10) ? 32'hDEADBEEF : 32'h1234_0000 + k;
      tick();
    end
    ap_ready = 1'b0; ap_done = 1'b0; ap_return = '0;
    total++; if (out_valid !== 1'b1 || out_result !== 32'hDEADBEEF || out_timeout !== 1'b0) begin bad++; $display("FAIL split_result got ov=%b res=%h tmo=%b exp=1/deadbeef/0", out_valid, out_result, out_timeout); end
    pop();
  endtask

  task automatic test_timeout();
    in_valid = 1'b1; in_a = 32'hA; in_b = 32'hB;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      total++; if (ap_start !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL tmo_running k=%0d got start=%b ov=%b exp=1/0", k, ap_start, out_valid); end
      tick();
    end
    // T+17
    total++; if (ap_start !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL tmo_drop got start=%b busy=%b exp=0/0", ap_start, busy); end
    total++; if (out_valid !== 1'b1 || out_timeout !== 1'b1 || out_result !== '0) begin bad++; $display("FAIL tmo_result got ov=%b tmo=%b res=%h exp=1/1/0", out_valid, out_timeout, out_result); end
    ap_done = 1'b1; ap_ready = 1'b1; ap_return = 32'd99;
    tick();
    ap_done = 1'b0; ap_ready = 1'b0; ap_return = '0;
    total++; if (out_valid !== 1'b1 || out_timeout !== 1'b1 || out_result !== '0) begin bad++; $display("FAIL tmo_late_done got ov=%b tmo=%b res=%h exp=1/1/0", out_valid, out_timeout, out_result); end
    pop();
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_a = 32'h1; in_b = 32'h2;
    tick();
    in_a = 32'h77; in_b = 32'h88;              // keep offering a second pair
    ap_ready = 1'b1; ap_done = 1'b1; ap_return = 32'h55AA;
    tick();
    ap_ready = 1'b0; ap_done = 1'b0; ap_return = 32'hBAD;
    for (int k = 0; k < 20; k++) begin
      total++; if (out_valid !== 1'b1 || out_result !== 32'h55AA) begin bad++; $display("FAIL bp_hold k=%0d got ov=%b res=%h exp=1/55aa", k, out_valid, out_result); end
      total++; if (in_ready !== 1'b0 || a !== 32'h1) begin bad++; $display("FAIL bp_no_accept k=%0d got rdy=%b a=%h exp=0/1", k, in_ready, a); end
      tick();
    end
    in_valid = 1'b0; ap_return = '0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got rdy=%b ov=%b exp=1/0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid_call();
    // Reset while in START: ap_start must drop without a clock edge.
    in_valid = 1'b1; in_a = 32'h3; in_b = 32'h4;
    tick();
    in_valid = 1'b0;
    #1 ap_rst_n = 1'b0;
    #1;
    total++; if (ap_start !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_start_async got start=%b busy=%b exp=0/0", ap_start, busy); end
    ap_rst_n = 1'b1;
    tick();
    // Reset while in WAIT.
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    tick();
    total++; if (busy !== 1'b1 || ap_start !== 1'b0) begin bad++; $display("FAIL rmid_in_wait got busy=%b start=%b exp=1/0", busy, ap_start); end
    #1 ap_rst_n = 1'b0;
    #1;
    total++; if (ap_start !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL rmid_wait_async got start=%b busy=%b ov=%b exp=0/0/0", ap_start, busy, out_valid); end
    ap_rst_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", in_ready); end
    ap_done = 1'b1; ap_return = 32'd77;
    tick();
    ap_done = 1'b0; ap_return = '0;
    for (int k = 0; k < 3; k++) begin
      total++; if (out_valid !== 1'b0 || out_result !== '0) begin bad++; $display("FAIL rmid_no_output k=%0d got ov=%b res=%h exp=0/0", k, out_valid, out_result); end
      tick();
    end
  endtask

  task automatic test_expiry_tie();
    in_valid = 1'b1; in_a = 32'h9; in_b = 32'h8;
    tick();                                    // T+1
    in_valid = 1'b0;
    ap_ready = 1'b1;
    tick();                                    // T+2
    ap_ready = 1'b0;
    repeat (14) tick();                        // T+16: expiry cycle
    total++; if (out_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL tie_pre got ov=%b busy=%b exp=0/1", out_valid, busy); end
    ap_done = 1'b1; ap_return = 32'd3;
    tick();                                    // T+17
    ap_done = 1'b0; ap_return = '0;
    total++; if (out_valid !== 1'b1 || out_result !== 32'd3 || out_timeout !== 1'b0) begin bad++; $display("FAIL tie_result got ov=%b res=%h tmo=%b exp=1/3/0", out_valid, out_result, out_timeout); end
    pop();
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_split();
    test_timeout();
    test_backpressure();
    test_reset_mid_call();
    test_expiry_tie();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_hs_driver.md
# calc_hs_driver

Initiator-side controller for the HLS `ap_ctrl_hs` block-level handshake used by the locked `calculate` cores. It accepts operand pairs on a valid/ready stream and latches them onto the callee's `a`/`b` inputs. It then raises and holds `ap_start`, captures `ap_return` on `ap_done`, and presents the result on a valid/ready output stream. A watchdog aborts a call whose callee never completes, for example a core running with a wrong working key.

## Interface
- `DATA_W`, 32: operand and result width.
- `TIMEOUT_CYCLES`, 1024: cycles allowed from `ap_start` rise to `ap_done` before abort; minimum 2.
- `CNT_W`, `$clog2(TIMEOUT_CYCLES+1)`: watchdog width, derived from `TIMEOUT_CYCLES`, not overridden.

Ports:
- `ap_clk`  in  1  clock, rising edge.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  driver can accept an operand pair.
- `in_a`, `in_b`  in  DATA_W  operands.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  DATA_W  captured `ap_return`; 0 on timeout.
- `out_timeout`  out  1  qualifies `out_result`; 1 means the call was aborted.
- `busy`  out  1  a call is in progress (state START or WAIT).
- `ap_start`  out  1  callee start.
- `ap_ready`  in  1  callee has consumed its inputs.
- `ap_done`  in  1  callee result strobe, one cycle.
- `ap_idle`  in  1  callee idle; status only, no effect on control.
- `a`, `b`  out  DATA_W  callee operands.
- `ap_return`  in  DATA_W  callee result, valid only in the `ap_done` cycle.

## Operation
- The FSM has four states: IDLE, START, WAIT and HOLD.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: register `in_a`/`in_b` into `a`/`b`, clear the watchdog, go to START.
- **START**
  - `ap_start`=1.
  - On `ap_ready`&`ap_done` in the same cycle: capture `ap_return`, go to HOLD.
  - On `ap_ready` alone: go to WAIT.
- **WAIT**
  - `ap_start`=0.
  - On `ap_done`: capture `ap_return`, set `out_timeout`=0, go to HOLD.
- **HOLD**
  - `out_valid`=1; `out_result` and `out_timeout` are held stable.
  - On `out_ready`: go to IDLE.
- **Operands:** `a`/`b` stay stable from the acceptance cycle through the `ap_done` cycle or the abort. They keep their value afterwards until the next accept.
- **Watchdog**
  - Counts every cycle in START and WAIT, and saturates.
  - On reaching `TIMEOUT_CYCLES` with no `ap_done` in that cycle: drop `ap_start`, load `out_result`=0 and `out_timeout`=1, go to HOLD.
  - `ap_done` in the same cycle as expiry wins; the result is normal.
- **Stray `ap_done`:** an `ap_done` seen in IDLE or HOLD, for example a late completion after an abort, is ignored and does not alter the held result.
- **No overlap:** `in_ready` is asserted only in IDLE, so there is one outstanding call at a time.
- **Reset mid-call:**
  - FSM returns to IDLE; `ap_start` drops immediately (asynchronous).
  - The partial result is discarded; no output is produced for the aborted call.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_result`=0, `out_timeout`=0, `busy`=0, `ap_start`=0, `a`=0, `b`=0.
- **Start:** accept at cycle T (`in_valid`&`in_ready`) → `ap_start`=1 and `busy`=1 from T+1.
- **Result:** `ap_done` at cycle D → `out_valid`=1 at D+1.
- **Minimum call latency:** 2 cycles from accept to `out_valid`, when `ap_ready`&`ap_done` arrive at T+1.
- **Abort:** with no `ap_done`, the watchdog expires at T+`TIMEOUT_CYCLES`; `out_valid` with `out_timeout`=1 follows at T+`TIMEOUT_CYCLES`+1.
- **Output handshake:** the result leaves on `out_valid`&`out_ready` at cycle R; `in_ready`=1 at R+1.
- **Peak throughput:** one call per (callee latency + 3) cycles.
- All outputs are registered except `in_ready` and `busy`, which are decoded directly from state.

## Structure
- Shared package `calc_hs_pkg`:
  - state enum `calc_hs_state_t` (IDLE, START, WAIT, HOLD);
  - `CALC_DATA_W`=32;
  - `CALC_TIMEOUT_DEFAULT`=1024.
- Sub-module `calc_hs_watchdog`:
  - saturating counter with `clr`, `en` and `expired` ports, parameterised by `TIMEOUT_CYCLES`;
  - instantiated once.

## Test plan
- **Zero-latency callee:** accept `a`=5, `b`=7; callee asserts `ap_ready`&`ap_done` at T+1 with `ap_return`=12 → `out_valid` at T+2, `out_result`=12, `out_timeout`=0.
- **Split ready/done:** `ap_ready` at T+3, `ap_done` at T+10 with `ap_return`=0xDEADBEEF → `ap_start` high T+1..T+3 only; `a`/`b` stable through T+10; `out_result`=0xDEADBEEF at T+11.
- **Timeout with a dead callee:** `TIMEOUT_CYCLES`=16, callee never responds → `ap_start` drops and `out_valid`=1 with `out_timeout`=1 and `out_result`=0 at T+17. A late `ap_done` with `ap_return`=99 during HOLD leaves `out_result`=0.
- **Output backpressure:** `out_ready` held low for 20 cycles → `out_valid` and `out_result` stay stable; `in_ready`=0 throughout; `in_ready`=1 the cycle after `out_ready` rises.
- **Reset mid-call:** assert `ap_rst_n`=0 in WAIT → `ap_start`, `busy` and `out_valid` are 0 asynchronously; after release `in_ready`=1 and a following `ap_done` produces no output.
- **Expiry tie:** `ap_done` arrives exactly at watchdog expiry with `ap_return`=3 → `out_result`=3, `out_timeout`=0.
